// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I pipeline types and constants
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {RUN, HALT} fetch_state_t;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;
endpackage

// File: rtl/if_pc_reg.sv
// if_pc_reg: program counter with reset/redirect/hold/+4 next-pc selection
module if_pc_reg import rv32i_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);
  // load beats hold so a redirect wins over a simultaneous stall
  always_ff @(posedge clk)
    pc <= rst ? RESET_PC : load ? target : hold ? pc : pc + 32'd4;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with IF/ID register, redirect, fault halt and fetch counter
module if_fetch_stage import rv32i_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_count
);
  fetch_state_t    state;
  if_id_t          r;
  logic [XLEN-1:0] pc;
  logic            run, aligned;
  assign run     = state == RUN;
  assign aligned = redirect_pc[1:0] == 2'b00;
  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .hold   (!run || redirect_valid || stall),
    .load   (run && redirect_valid && aligned),
    .target (redirect_pc),
    .pc     (pc)
  );
  assign imem_addr   = pc;
  assign if_valid    = r.valid;
  assign if_pc       = r.pc;
  assign if_pc_plus4 = r.pc_plus4;
  assign if_instr    = r.instr;
  // IF/ID capture, flush on redirect or halt, misaligned target halts until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      r           <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: NOP_INSTR};
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else if (!run || redirect_valid) begin
      r.valid <= 1'b0;
      r.instr <= NOP_INSTR;
      if (run && !aligned) begin
        fetch_fault <= 1'b1;
        state       <= HALT;
      end
    end else if (!stall) begin
      r           <= '{valid: 1'b1, pc: pc, pc_plus4: pc + 32'd4, instr: imem_instr};
      fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule
